des_key_schedule: RTL

//   Iterative DES key schedule. Takes a 64-bit DES key and emits the sixteen 48-bit round subkeys,
//   one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).

---
 rtl/des_key_schedule.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 load, per-round C/D rotation, registered PC-2 subkey output.
// Emits K1..K16 (encrypt) or K16..K1 (decrypt), one subkey per valid/ready handshake.
module des_key_schedule #(
    parameter bit STALL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StGen, StFin} state_e;

    localparam int unsigned Pc1Table [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned Pc2Table [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Tables are 1-based from the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-Pc1Table[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-Pc2Table[i]];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; all others by two.
    function automatic logic shift_two(input logic [4:0] rnd);
        return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic [47:0] subkey_q;
    logic [55:0] key_pc1;
    logic        handshake;
    logic        two_enc, two_dec;

    assign key_pc1   = pc1(key_in);
    assign handshake = (state_q == StGen) && (subkey_ready || !STALL_EN);
    assign two_enc   = shift_two({1'b0, idx_q} + 5'd2);
    assign two_dec   = shift_two(5'd16 - {1'b0, idx_q});

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dec_d   = decrypt;
                    idx_d   = 4'd0;
                    state_d = StGen;
                    // Decrypt starts from C16/D16, which equal C0/D0.
                    if (decrypt) begin
                        c_d = key_pc1[55:28];
                        d_d = key_pc1[27:0];
                    end else begin
                        c_d = rol(key_pc1[55:28], 1'b0);
                        d_d = rol(key_pc1[27:0], 1'b0);
                    end
                end
            end
            StGen: begin
                if (handshake) begin
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = StFin;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (dec_q) begin
                            c_d = ror(c_q, two_dec);
                            d_d = ror(d_q, two_dec);
                        end else begin
                            c_d = rol(c_q, two_enc);
                            d_d = rol(d_q, two_enc);
                        end
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            c_q      <= '0;
            d_q      <= '0;
            idx_q    <= '0;
            dec_q    <= 1'b0;
            subkey_q <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            idx_q    <= idx_d;
            dec_q    <= dec_d;
            subkey_q <= pc2({c_d, d_d});
        end
    end

    assign subkey       = subkey_q;
    assign subkey_valid = (state_q == StGen);
    assign round_idx    = idx_q;
    assign busy         = (state_q == StGen);
    assign done         = (state_q == StFin);

endmodule
